// File: rtl/lnk_seq_checker_pkg.sv
// ---------------------------------------------------------------------------
// lnk_seq_checker_pkg
//   Shared types and constants for the NS-link receive-side sequence checker:
//   default field widths, FSM state encoding, error codes, the per-message
//   check-flag bundle and the error-priority encoder.
// ---------------------------------------------------------------------------
package lnk_seq_checker_pkg;

    // Default NS link field widths.
    localparam int DEF_ASZ = 8;
    localparam int DEF_DSZ = 8;
    localparam int DEF_RSZ = 4;

    // Handshake FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Error codes, exported on the debug display once latched.
    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_SEQ   = 3'd1,
        ERR_RANGE = 3'd2,
        ERR_DST   = 3'd3,
        ERR_RED   = 3'd4
    } err_code_t;

    // Result of every individual check on one captured message.
    typedef struct packed {
        logic seq;
        logic range;
        logic dst;
        logic red;
    } chk_flags_t;

    // Several checks may fail on one message; the lowest code is reported.
    function automatic err_code_t err_prio(input chk_flags_t f);
        if (f.seq)   return ERR_SEQ;
        if (f.range) return ERR_RANGE;
        if (f.dst)   return ERR_DST;
        if (f.red)   return ERR_RED;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/lnk_seq_checker_sync2.sv
// ---------------------------------------------------------------------------
// lnk_seq_checker_sync2
//   Two-flop synchroniser for a single asynchronous control bit.
//   Ports:
//     i_clk  in   destination clock
//     reset  in   synchronous active-high reset, clears both flops
//     d      in   asynchronous input
//     q      out  input delayed by two i_clk edges
// ---------------------------------------------------------------------------
module lnk_seq_checker_sync2 (
    input  logic i_clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make both flops sample the old values,
    // giving a true two-stage shift instead of a single wire-through.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lnk_seq_checker.sv
// ---------------------------------------------------------------------------
// lnk_seq_checker
//   Receive-side checker for one NS link. Each message is accepted with a
//   4-phase req/ack handshake and checked for sequence order, source-address
//   range, destination match and redundancy. The first error is latched and
//   debug nibbles / LEDs are exported for a 7-segment display driver.
//   Ports:
//     i_clk      in   single clock
//     reset      in   synchronous active-high reset
//     ready      out  checker out of reset
//     rcv0_req   in   sender request; fields stable while high
//     rcv0_ack   out  receiver acknowledge
//     rcv0_src   in   message source address      [ASZ]
//     rcv0_dst   in   message destination address [ASZ]
//     rcv0_dat   in   message payload             [DSZ]
//     rcv0_red   in   message redundancy          [RSZ]
//     o_msg_cnt  out  accepted-message count, wraps at 2^16
//     o_err      out  sticky error flag
//     o_leds     out  {msg_cnt[7], err, >=1 message, ready}
//     o_disp0    out  msg_cnt[3:0], or latched bad dat[3:0] after an error
//     o_disp1    out  msg_cnt[7:4], or latched error code after an error
// ---------------------------------------------------------------------------
module lnk_seq_checker
    import lnk_seq_checker_pkg::*;
#(
    parameter int ASZ         = DEF_ASZ,
    parameter int DSZ         = DEF_DSZ,
    parameter int RSZ         = DEF_RSZ,
    parameter int MIN_ADDR    = 0,
    parameter int MAX_ADDR    = 55,
    parameter int MY_ADDR     = 23,
    parameter bit SYNC_REQ    = 1'b1,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    output logic [15:0]    o_msg_cnt,
    output logic           o_err,
    output logic [3:0]     o_leds,
    output logic [3:0]     o_disp0,
    output logic [3:0]     o_disp1
);

    // -----------------------------------------------------------------------
    // Request synchronisation
    // -----------------------------------------------------------------------
    logic req_s;

    generate
        if (SYNC_REQ) begin : g_sync
            lnk_seq_checker_sync2 u_sync (
                .i_clk (i_clk),
                .reset (reset),
                .d     (rcv0_req),
                .q     (req_s)
            );
        end else begin : g_nosync
            assign req_s = rcv0_req;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t         state_q;
    state_t         state_d;
    logic [DSZ-1:0] exp_q;       // next expected payload
    logic [15:0]    cnt_q;
    logic           seen_q;      // at least one message accepted since reset
    logic           err_q;
    err_code_t      err_code_q;
    logic [3:0]     err_dat_q;

    // A message is captured on the edge that moves IDLE -> ACK; the sender
    // holds the fields stable while req is high, so they are checked directly.
    logic capture;
    assign capture = (state_q == ST_IDLE) && req_s;

    // -----------------------------------------------------------------------
    // Message checks
    // -----------------------------------------------------------------------
    int             src_int;     // signed view so a zero MIN_ADDR compares cleanly
    logic [RSZ-1:0] red_exp;
    chk_flags_t     flags;
    err_code_t      code_d;

    assign src_int = int'(rcv0_src);
    assign red_exp = rcv0_dat[RSZ-1:0] ^ rcv0_src[RSZ-1:0] ^ rcv0_dst[RSZ-1:0];

    always_comb begin
        flags.seq   = (rcv0_dat != exp_q);
        flags.range = (src_int < MIN_ADDR) || (src_int > MAX_ADDR);
        flags.dst   = (rcv0_dst != ASZ'(MY_ADDR));
        flags.red   = (rcv0_red != red_exp);
    end

    assign code_d = err_prio(flags);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_s) state_d = ST_ACK;
            ST_ACK: begin
                // err_q already includes an error found on this handshake.
                if (!req_s) state_d = (STOP_ON_ERR && err_q) ? ST_HALT : ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (ack is a pure state decode, so it is glitch-free)
    // -----------------------------------------------------------------------
    always_comb begin
        rcv0_ack = (state_q == ST_ACK);
    end

    // -----------------------------------------------------------------------
    // Datapath: sequence tracking, counters and first-error latch
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (reset) begin
            ready      <= 1'b0;
            exp_q      <= '0;
            cnt_q      <= '0;
            seen_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_dat_q  <= '0;
        end else begin
            ready <= 1'b1;
            if (capture) begin
                // Re-sync to the received value so a single gap reports once.
                exp_q  <= rcv0_dat + DSZ'(1);
                cnt_q  <= cnt_q + 16'd1;
                seen_q <= 1'b1;
                if (!err_q && (code_d != ERR_NONE)) begin
                    err_q      <= 1'b1;
                    err_code_q <= code_d;
                    err_dat_q  <= rcv0_dat[3:0];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Debug outputs
    // -----------------------------------------------------------------------
    assign o_msg_cnt = cnt_q;
    assign o_err     = err_q;
    assign o_leds    = {cnt_q[7], err_q, seen_q, ready};
    assign o_disp0   = err_q ? err_dat_q : cnt_q[3:0];
    assign o_disp1   = err_q ? {1'b0, err_code_q} : cnt_q[7:4];

endmodule

// File: tb/tb_lnk_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_lnk_seq_checker
//   Directed bench for lnk_seq_checker. Instance "a" uses the synchronised
//   request and keeps acking after errors; instance "b" uses the raw request
//   and halts after its first error. Both share clock, reset and fields.
// ---------------------------------------------------------------------------
module tb_lnk_seq_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [7:0]  src = '0;
    logic [7:0]  dst = '0;
    logic [7:0]  dat = '0;
    logic [3:0]  red = '0;

    logic        ready_a, ack_a, err_a;
    logic [15:0] cnt_a;
    logic [3:0]  leds_a, disp0_a, disp1_a;
    logic        ready_b, ack_b, err_b;
    logic [15:0] cnt_b;
    logic [3:0]  leds_b, disp0_b, disp1_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lnk_seq_checker #(
        .ASZ(8), .DSZ(8), .RSZ(4), .MIN_ADDR(0), .MAX_ADDR(55), .MY_ADDR(23),
        .SYNC_REQ(1'b1), .STOP_ON_ERR(1'b0)
    ) dut_a (
        .i_clk(clk), .reset(reset), .ready(ready_a),
        .rcv0_req(req_a), .rcv0_ack(ack_a),
        .rcv0_src(src), .rcv0_dst(dst), .rcv0_dat(dat), .rcv0_red(red),
        .o_msg_cnt(cnt_a), .o_err(err_a), .o_leds(leds_a),
        .o_disp0(disp0_a), .o_disp1(disp1_a)
    );

    lnk_seq_checker #(
        .ASZ(8), .DSZ(8), .RSZ(4), .MIN_ADDR(0), .MAX_ADDR(55), .MY_ADDR(23),
        .SYNC_REQ(1'b0), .STOP_ON_ERR(1'b1)
    ) dut_b (
        .i_clk(clk), .reset(reset), .ready(ready_b),
        .rcv0_req(req_b), .rcv0_ack(ack_b),
        .rcv0_src(src), .rcv0_dst(dst), .rcv0_dat(dat), .rcv0_red(red),
        .o_msg_cnt(cnt_b), .o_err(err_b), .o_leds(leds_b),
        .o_disp0(disp0_b), .o_disp1(disp1_b)
    );

    function automatic logic [3:0] red_of(input logic [7:0] d, input logic [7:0] s,
                                          input logic [7:0] t);
        return d[3:0] ^ s[3:0] ^ t[3:0];
    endfunction

    // Full 4-phase handshake; reports edges from req change to ack change.
    // A missing ack within 10 cycles is a failed comparison.
    task automatic send(input bit use_b, input logic [7:0] d, input logic [7:0] s,
                        input logic [7:0] t, input logic [3:0] r,
                        output int rise, output int fall);
        dat = d; src = s; dst = t; red = r;
        if (use_b) req_b = 1'b1; else req_a = 1'b1;
        rise = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if ((use_b ? ack_b : ack_a) === 1'b1) begin rise = i; break; end
        end
        if (use_b) req_b = 1'b0; else req_a = 1'b0;
        fall = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if ((use_b ? ack_b : ack_a) === 1'b0) begin fall = i; break; end
        end
        checks++;
        if (rise < 0 || fall < 0) begin
            errors++;
            $display("FAIL handshake dat=%0d: rise=%0d fall=%0d, required both acked within 10",
                     d, rise, fall);
        end
    endtask

    task automatic send_ok(input bit use_b, input logic [7:0] d);
        int r, f;
        send(use_b, d, 8'd5, 8'd23, red_of(d, 8'd5, 8'd23), r, f);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready_a); end
        checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", ack_a); end
        checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", cnt_a); end
        checks++; if (leds_a !== 4'b0000) begin errors++; $display("FAIL rst_leds: got %b want 0000", leds_a); end
        checks++; if ({disp1_a, disp0_a} !== 8'h00) begin errors++; $display("FAIL rst_disp: got %h want 00", {disp1_a, disp0_a}); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", ready_a); end
        checks++; if (leds_a !== 4'b0001) begin errors++; $display("FAIL rel_leds: got %b want 0001", leds_a); end
        checks++; if (ack_a !== 1'b0 || cnt_a !== 16'd0) begin errors++; $display("FAIL rel_ack_cnt: got ack=%b cnt=%0d want 0/0", ack_a, cnt_a); end
    endtask

    task automatic test_latency();
        int r, f;
        do_reset();
        send(1'b0, 8'd0, 8'd5, 8'd23, red_of(8'd0, 8'd5, 8'd23), r, f);
        checks++; if (r != 3 || f != 3) begin errors++; $display("FAIL lat_sync: got rise=%0d fall=%0d want 3/3", r, f); end
        send(1'b1, 8'd0, 8'd5, 8'd23, red_of(8'd0, 8'd5, 8'd23), r, f);
        checks++; if (r != 1 || f != 1) begin errors++; $display("FAIL lat_raw: got rise=%0d fall=%0d want 1/1", r, f); end
        checks++; if (cnt_a !== 16'd1 || err_a !== 1'b0) begin errors++; $display("FAIL lat_cnt: got cnt=%0d err=%b want 1/0", cnt_a, err_a); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 20; i++) send_ok(1'b0, 8'(i));
        checks++; if (cnt_a !== 16'd20) begin errors++; $display("FAIL stream_cnt: got %0d want 20", cnt_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL stream_err: got %b want 0", err_a); end
        checks++; if (disp0_a !== 4'd4 || disp1_a !== 4'd1) begin errors++; $display("FAIL stream_disp: got %h/%h want 1/4", disp1_a, disp0_a); end
        checks++; if (leds_a !== 4'b0011) begin errors++; $display("FAIL stream_leds: got %b want 0011", leds_a); end
        // Sub-cycle glitch between rising edges must never be captured.
        #1 req_a = 1'b1;
        #2 req_a = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (ack_a !== 1'b0 || cnt_a !== 16'd20) begin errors++; $display("FAIL glitch: got ack=%b cnt=%0d want 0/20", ack_a, cnt_a); end
    endtask

    task automatic test_seq_gap();
        do_reset();
        send_ok(1'b0, 8'd0);
        send_ok(1'b0, 8'd1);
        send_ok(1'b0, 8'd2);
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL gap_pre: got err=%b want 0", err_a); end
        send_ok(1'b0, 8'd4);
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL gap_err: got err=%b want 1", err_a); end
        checks++; if (disp1_a !== 4'd1 || disp0_a !== 4'd4) begin errors++; $display("FAIL gap_disp: got %h/%h want 1/4", disp1_a, disp0_a); end
        send_ok(1'b0, 8'd5);
        checks++; if (disp1_a !== 4'd1 || disp0_a !== 4'd4) begin errors++; $display("FAIL gap_keep: got %h/%h want 1/4", disp1_a, disp0_a); end
        checks++; if (cnt_a !== 16'd5) begin errors++; $display("FAIL gap_cnt: got %0d want 5", cnt_a); end
        checks++; if (leds_a !== 4'b0111) begin errors++; $display("FAIL gap_leds: got %b want 0111", leds_a); end
    endtask

    task automatic test_addr_bounds();
        int r, f;
        do_reset();
        send(1'b0, 8'd0, 8'd0, 8'd23, red_of(8'd0, 8'd0, 8'd23), r, f);
        send(1'b0, 8'd1, 8'd55, 8'd23, red_of(8'd1, 8'd55, 8'd23), r, f);
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL bound_legal: got err=%b want 0", err_a); end
        send(1'b0, 8'd2, 8'd56, 8'd23, red_of(8'd2, 8'd56, 8'd23), r, f);
        checks++; if (err_a !== 1'b1 || disp1_a !== 4'd2 || disp0_a !== 4'd2) begin errors++; $display("FAIL bound_56: got err=%b disp=%h/%h want 1 2/2", err_a, disp1_a, disp0_a); end
    endtask

    task automatic test_range_prio();
        int r, f;
        do_reset();
        send_ok(1'b0, 8'd0);
        // Range, destination and redundancy all wrong: range wins.
        send(1'b0, 8'd1, 8'd56, 8'd40, red_of(8'd1, 8'd56, 8'd40) ^ 4'd1, r, f);
        checks++; if (disp1_a !== 4'd2 || disp0_a !== 4'd1) begin errors++; $display("FAIL prio_code: got %h/%h want 2/1", disp1_a, disp0_a); end
        send(1'b0, 8'd2, 8'd5, 8'd23, red_of(8'd2, 8'd5, 8'd23) ^ 4'd8, r, f);
        checks++; if (disp1_a !== 4'd2 || disp0_a !== 4'd1) begin errors++; $display("FAIL prio_sticky: got %h/%h want 2/1", disp1_a, disp0_a); end
        checks++; if (cnt_a !== 16'd3) begin errors++; $display("FAIL prio_cnt: got %0d want 3", cnt_a); end
        send(1'b0, 8'd3, 8'd5, 8'd22, red_of(8'd3, 8'd5, 8'd22), r, f);
        checks++; if (disp1_a !== 4'd2) begin errors++; $display("FAIL prio_dst_ign: got %h want 2", disp1_a); end
    endtask

    task automatic test_stop_on_err();
        bit seen_ack;
        do_reset();
        send_ok(1'b1, 8'd0);
        send_ok(1'b1, 8'd2);
        checks++; if (err_b !== 1'b1 || disp1_b !== 4'd1 || disp0_b !== 4'd2) begin errors++; $display("FAIL halt_err: got err=%b disp=%h/%h want 1 1/2", err_b, disp1_b, disp0_b); end
        checks++; if (cnt_b !== 16'd2) begin errors++; $display("FAIL halt_cnt: got %0d want 2", cnt_b); end
        dat = 8'd3; src = 8'd5; dst = 8'd23; red = red_of(8'd3, 8'd5, 8'd23);
        req_b = 1'b1;
        seen_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_b !== 1'b0) seen_ack = 1'b1;
        end
        req_b = 1'b0;
        @(negedge clk);
        checks++; if (seen_ack !== 1'b0) begin errors++; $display("FAIL halt_noack: got ack seen=%b want 0", seen_ack); end
        checks++; if (cnt_b !== 16'd2) begin errors++; $display("FAIL halt_cnt2: got %0d want 2", cnt_b); end
    endtask

    task automatic test_reset_mid();
        bit got;
        do_reset();
        dat = 8'd0; src = 8'd5; dst = 8'd23; red = red_of(8'd0, 8'd5, 8'd23);
        req_a = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_a === 1'b1) begin got = 1'b1; break; end
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL mid_ack: got ack=%b want 1", ack_a); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ack_a !== 1'b0 || cnt_a !== 16'd0) begin errors++; $display("FAIL mid_rst: got ack=%b cnt=%0d want 0/0", ack_a, cnt_a); end
        req_a = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_ok(1'b0, 8'(i));
        checks++; if (err_a !== 1'b0 || cnt_a !== 16'd4) begin errors++; $display("FAIL mid_stream: got err=%b cnt=%0d want 0/4", err_a, cnt_a); end
        checks++; if (disp0_a !== 4'd4) begin errors++; $display("FAIL mid_disp0: got %h want 4", disp0_a); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stream();
        test_seq_gap();
        test_addr_bounds();
        test_range_prio();
        test_stop_on_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
